// File: rtl/mul_j4_pkg.sv
// Shared constants and helpers for the J=4 unfolded multiplier datapath.
package mul_j4_pkg;

   localparam int J      = 4;   // lanes produced per beat by the unfolded multiplier
   localparam int PW_DEF = 10;  // default product width (5b x 5b)

   // Ceiling log2; returns 0 for n <= 1, callers clamp widths where needed.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/add4_tree.sv
// Two-level combinational adder for one beat of J=4 products.
module add4_tree
   import mul_j4_pkg::*;
#(
   parameter int PW = PW_DEF
) (
   input  logic [J-1:0][PW-1:0] lanes_i,
   output logic [PW+1:0]        sum_o
);

   logic [PW:0] sum01;
   logic [PW:0] sum23;

   // Pairwise sums first so each level only grows by one bit.
   assign sum01 = {1'b0, lanes_i[0]} + {1'b0, lanes_i[1]};
   assign sum23 = {1'b0, lanes_i[2]} + {1'b0, lanes_i[3]};
   assign sum_o = {1'b0, sum01} + {1'b0, sum23};

endmodule

// File: rtl/mul_j4_block_accumulator.sv
// Sums four lane products per beat and accumulates NBLK beats into one
// dot-product result delivered on a valid/ready output.
module mul_j4_block_accumulator
   import mul_j4_pkg::*;
#(
   parameter  int PW   = PW_DEF,
   parameter  int NBLK = 4,
   localparam int AW   = PW + 2 + clog2(NBLK),
   localparam int CW   = (NBLK > 1) ? clog2(NBLK) : 1
) (
   input  logic          clk,
   input  logic          reset,      // active-low, asynchronous
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] s_0,
   input  logic [PW-1:0] s_1,
   input  logic [PW-1:0] s_2,
   input  logic [PW-1:0] s_3,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] acc_out,
   output logic [CW-1:0] blk_cnt
);

   logic [J-1:0][PW-1:0] lanes;
   logic [PW+1:0]        tree_sum;

   logic                 p1_valid_q, p1_valid_d;
   logic [PW+1:0]        p1_sum_q,   p1_sum_d;
   logic [AW-1:0]        acc_q,      acc_d;
   logic [CW-1:0]        blk_cnt_q,  blk_cnt_d;
   logic [AW-1:0]        acc_out_q,  acc_out_d;
   logic                 out_valid_q, out_valid_d;

   logic                 last;
   logic                 adv2;
   logic                 accept;
   logic [AW-1:0]        acc_nxt;

   assign lanes = {s_3, s_2, s_1, s_0};

   add4_tree #(.PW(PW)) u_tree (
      .lanes_i (lanes),
      .sum_o   (tree_sum)
   );

   // The ACC stage only stalls when it would overwrite an unconsumed result.
   assign last     = (blk_cnt_q == CW'(NBLK - 1));
   assign adv2     = p1_valid_q && !(last && out_valid_q && !out_ready);
   assign in_ready = !p1_valid_q || adv2;
   assign accept   = in_valid && in_ready;
   assign acc_nxt  = acc_q + AW'(p1_sum_q);

   // P1 next state: load on accept, drain when ACC takes it, otherwise hold.
   always_comb begin
      p1_valid_d = p1_valid_q;
      p1_sum_d   = p1_sum_q;
      if (accept) begin
         p1_valid_d = 1'b1;
         p1_sum_d   = tree_sum;
      end else if (adv2) begin
         p1_valid_d = 1'b0;
      end
   end

   // ACC and output next state; a new result may replace one leaving this edge.
   always_comb begin
      acc_d       = acc_q;
      blk_cnt_d   = blk_cnt_q;
      acc_out_d   = acc_out_q;
      out_valid_d = out_valid_q;
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (adv2) begin
         if (last) begin
            acc_out_d   = acc_nxt;
            out_valid_d = 1'b1;
            acc_d       = '0;
            blk_cnt_d   = '0;
         end else begin
            acc_d       = acc_nxt;
            blk_cnt_d   = blk_cnt_q + CW'(1);
         end
      end
   end

   // State registers; reset discards any partial accumulation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p1_valid_q  <= 1'b0;
         p1_sum_q    <= '0;
         acc_q       <= '0;
         blk_cnt_q   <= '0;
         acc_out_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         p1_valid_q  <= p1_valid_d;
         p1_sum_q    <= p1_sum_d;
         acc_q       <= acc_d;
         blk_cnt_q   <= blk_cnt_d;
         acc_out_q   <= acc_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign acc_out   = acc_out_q;
   assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_mul_j4_block_accumulator.sv
// Directed bench for mul_j4_block_accumulator at default parameters.
module tb_mul_j4_block_accumulator;

   localparam int PW   = 10;
   localparam int NBLK = 4;
   localparam int AW   = 14;
   localparam int CW   = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [PW-1:0] s_0, s_1, s_2, s_3;
   logic [AW-1:0] acc_out;
   logic [CW-1:0] blk_cnt;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc   = 0;
   logic [AW-1:0] got_q[$];
   int            got_cyc[$];

   typedef struct {
      string                     name;
      logic [3:0][3:0][PW-1:0]   s;     // [beat][lane]
      logic [AW-1:0]             exp;
   } vec_t;
   vec_t vecs[5];

   always #5 clk = ~clk;

   mul_j4_block_accumulator #(.PW(PW), .NBLK(NBLK)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .s_0       (s_0),
      .s_1       (s_1),
      .s_2       (s_2),
      .s_3       (s_3),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc_out   (acc_out),
      .blk_cnt   (blk_cnt)
   );

   // Record every completed output handshake and the cycle it happened on.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset && out_valid && out_ready) begin
         got_q.push_back(acc_out);
         got_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] pop();
      if (got_q.size() > 0) return got_q.pop_front();
      return '1;
   endfunction

   task automatic send(input logic [PW-1:0] a, b, c, d);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      s_0 = a; s_1 = b; s_2 = c; s_3 = d;
      for (int k = 0; k < 50; k++) begin
         #1;
         if (in_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: in_ready got 0 expected 1");
      end
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_results(input int n, input string name);
      for (int k = 0; k < 100 && got_q.size() < n; k++) @(negedge clk);
      chk({name, "_count"}, got_q.size(), n);
   endtask

   initial begin
      int c0;
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      s_0 = '0; s_1 = '0; s_2 = '0; s_3 = '0;

      vecs[0].name = "basic15";
      vecs[1].name = "max1023";
      vecs[2].name = "ramp";
      vecs[3].name = "zero";
      vecs[4].name = "lane0_only";
      for (int b = 0; b < 4; b++)
         for (int l = 0; l < 4; l++) begin
            vecs[0].s[b][l] = 10'd15;
            vecs[1].s[b][l] = 10'd1023;
            vecs[2].s[b][l] = PW'(b * 4 + l + 1);
            vecs[3].s[b][l] = 10'd0;
            vecs[4].s[b][l] = (l == 0) ? 10'd1000 : 10'd0;
         end
      vecs[0].exp = 14'd240;
      vecs[1].exp = 14'd16368;
      vecs[2].exp = 14'd136;
      vecs[3].exp = 14'd0;
      vecs[4].exp = 14'd4000;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_acc_out",   acc_out,   0);
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_blk_cnt",   blk_cnt,   0);
      reset = 1'b1;

      // Table-driven results, streaming with out_ready high
      for (int i = 0; i < 5; i++) begin
         got_q.delete();
         for (int b = 0; b < 4; b++)
            send(vecs[i].s[b][0], vecs[i].s[b][1], vecs[i].s[b][2], vecs[i].s[b][3]);
         idle();
         wait_results(1, vecs[i].name);
         chk(vecs[i].name, pop(), vecs[i].exp);
      end

      // Latency and single-cycle out_valid
      repeat (2) idle();
      got_q.delete();
      for (int b = 0; b < 4; b++) send(10'd15, 10'd15, 10'd15, 10'd15);
      @(negedge clk); in_valid = 1'b0; #1;
      chk("lat_early_valid", out_valid, 0);
      chk("lat_blk_cnt3",    blk_cnt,   3);
      @(negedge clk);
      chk("lat_valid",       out_valid, 1);
      chk("lat_acc_out",     acc_out,   240);
      @(negedge clk);
      chk("lat_valid_drop",  out_valid, 0);
      chk("lat_blk_wrap",    blk_cnt,   0);

      // Backpressure: two results of 16 while the consumer is stalled
      @(negedge clk); out_ready = 1'b0;
      got_q.delete();
      for (int b = 0; b < 8; b++) send(10'd1, 10'd1, 10'd1, 10'd1);
      @(negedge clk); in_valid = 1'b0; #1;
      chk("bp_in_ready_low", in_ready,  0);
      chk("bp_out_valid",    out_valid, 1);
      chk("bp_acc_out",      acc_out,   16);
      chk("bp_blk_cnt",      blk_cnt,   3);
      repeat (3) @(negedge clk);
      #1;
      chk("bp_acc_hold",     acc_out,   16);
      chk("bp_still_stall",  in_ready,  0);
      chk("bp_no_handshake", got_q.size(), 0);
      out_ready = 1'b1; #1;
      chk("bp_release_ready", in_ready, 1);
      wait_results(2, "bp");
      chk("bp_first",  pop(), 16);
      chk("bp_second", pop(), 16);

      // Bubbles inside a result leave the sum unchanged
      idle();
      got_q.delete();
      send(10'd1, 10'd2, 10'd3, 10'd4);
      send(10'd1, 10'd2, 10'd3, 10'd4);
      idle();
      repeat (2) @(negedge clk);
      chk("gap_blk_cnt", blk_cnt, 2);
      send(10'd10, 10'd20, 10'd30, 10'd40);
      send(10'd10, 10'd20, 10'd30, 10'd40);
      idle();
      wait_results(1, "gap");
      chk("gap_sum", pop(), 220);

      // Back-to-back results arrive exactly NBLK cycles apart
      got_q.delete(); got_cyc.delete();
      for (int b = 0; b < 8; b++) send(10'd7, 10'd7, 10'd7, 10'd7);
      idle();
      wait_results(2, "b2b");
      c0 = (got_cyc.size() >= 2) ? (got_cyc[1] - got_cyc[0]) : -1;
      chk("b2b_first",   pop(), 112);
      chk("b2b_second",  pop(), 112);
      chk("b2b_spacing", c0, NBLK);

      // Reset mid-result discards the partial sum
      got_q.delete();
      send(10'd9, 10'd9, 10'd9, 10'd9);
      send(10'd9, 10'd9, 10'd9, 10'd9);
      @(negedge clk); in_valid = 1'b0; reset = 1'b0;
      @(negedge clk); #1;
      chk("mrst_blk_cnt",   blk_cnt,   0);
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_in_ready",  in_ready,  1);
      reset = 1'b1;
      for (int b = 0; b < 4; b++) send(10'd2, 10'd2, 10'd2, 10'd2);
      idle();
      wait_results(1, "mrst");
      chk("mrst_sum", pop(), 32);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
